// File: rtl/sd_sector_streamer.sv
// Multi-sector SD block reader feeding a byte FIFO with a zero-latency head.
// A sector is only requested once the FIFO can hold all of it, because the SD controller cannot be stalled mid-block.
module sd_sector_streamer #(
   parameter int FIFO_DEPTH   = 1024,
   parameter int SECTOR_BYTES = 512
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [22:0] start_sector,
   input  logic [15:0] num_sectors,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   input  logic        sd_ready,
   output logic        sd_rd,
   output logic [31:0] sd_address,
   input  logic [7:0]  sd_dout,
   input  logic        sd_byte_available,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(SECTOR_BYTES) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_SPACE, S_ISSUE, S_STREAM, S_WAIT_IDLE, S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [22:0]    sector_q, sector_d;
   logic [15:0]    remaining_q, remaining_d;
   logic [BW-1:0]  byte_cnt_q, byte_cnt_d;
   logic           abort_q, abort_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           overflow_q, overflow_d;
   logic           sba_q;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;

   logic [7:0]     mem [FIFO_DEPTH];

   logic capture, push_req, push, pop, full, free_ok, last_byte, abort_pend;

   always_comb begin
      capture    = sd_byte_available & ~sba_q;
      push_req   = (state_q == S_STREAM) & capture;
      full       = (count_q == CW'(FIFO_DEPTH));
      push       = push_req & ~full;
      pop        = (count_q != '0) & out_ready;
      free_ok    = (CW'(FIFO_DEPTH) - count_q) >= CW'(SECTOR_BYTES);
      last_byte  = (byte_cnt_q == BW'(SECTOR_BYTES - 1));
      abort_pend = abort_q | abort;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:
            if (start) state_d = (num_sectors != 16'd0) ? S_WAIT_SPACE : S_DONE;
         S_WAIT_SPACE:
            if (abort_pend)             state_d = S_DONE;
            else if (free_ok && sd_ready) state_d = S_ISSUE;
         S_ISSUE:
            if (!sd_ready) state_d = S_STREAM;
         S_STREAM:
            if (push_req && last_byte) state_d = S_WAIT_IDLE;
         S_WAIT_IDLE:
            if (sd_ready) state_d = (remaining_q == 16'd1 || abort_pend) ? S_DONE : S_WAIT_SPACE;
         S_DONE:
            state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sector_d    = sector_q;
      remaining_d = remaining_q;
      byte_cnt_d  = byte_cnt_q;
      abort_d     = abort_q;
      busy_d      = busy_q;
      overflow_d  = overflow_q;
      done_d      = (state_q == S_DONE);
      sd_rd       = (state_q == S_ISSUE);

      if (abort && state_q != S_IDLE) abort_d = 1'b1;
      if (push_req && full)           overflow_d = 1'b1;

      case (state_q)
         S_IDLE:
            if (start) begin
               overflow_d = 1'b0;
               if (num_sectors != 16'd0) begin
                  sector_d    = start_sector;
                  remaining_d = num_sectors;
                  busy_d      = 1'b1;
               end
            end
         S_STREAM:
            if (push_req) byte_cnt_d = last_byte ? '0 : byte_cnt_q + BW'(1);
         S_WAIT_IDLE:
            if (sd_ready) begin
               sector_d    = sector_q + 23'd1;
               remaining_d = remaining_q - 16'd1;
            end
         S_DONE: begin
            busy_d  = 1'b0;
            abort_d = 1'b0;
         end
         default: ;
      endcase

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sector_q    <= '0;
         remaining_q <= '0;
         byte_cnt_q  <= '0;
         abort_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
         sba_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         sector_q    <= sector_d;
         remaining_q <= remaining_d;
         byte_cnt_q  <= byte_cnt_d;
         abort_q     <= abort_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         overflow_q  <= overflow_d;
         sba_q       <= sd_byte_available;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Storage is not reset; emptiness is tracked by count_q and out_data is masked while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= sd_dout;
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign overflow   = overflow_q;
   assign sd_address = {sector_q, 9'b0};
   assign out_valid  = (count_q != '0);
   assign out_data   = out_valid ? mem[rd_ptr_q] : 8'h00;

endmodule
